// File: rtl/str_unpack.sv
// Stream unpacker: accepts wide words tagged with a count of valid sub-words
// and emits only those sub-words, LSB first, as a narrow val/rdy/last stream.
// A single holding register is reloaded in the same cycle its final sub-word
// is consumed, so consecutive words stream with no idle downstream cycle.
module str_unpack #(
    parameter int DATA_UP_WIDTH = 32,
    parameter int DATA_DN_WIDTH = 8,
    parameter int CNT_WIDTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_UP_WIDTH-1:0] up_data,
    input  logic [CNT_WIDTH-1:0]     up_cnt,
    input  logic                     up_last,
    input  logic                     up_val,
    output logic                     up_rdy,
    output logic [DATA_DN_WIDTH-1:0] dn_data,
    output logic                     dn_last,
    output logic                     dn_val,
    input  logic                     dn_rdy
);

    localparam int DATA_NB   = DATA_UP_WIDTH / DATA_DN_WIDTH;
    // One extra bit so the remaining count can hold DATA_NB itself.
    localparam int REM_WIDTH = CNT_WIDTH + 1;

    logic [DATA_UP_WIDTH-1:0] r_hold;
    logic [REM_WIDTH-1:0]     r_rem;
    logic                     r_hold_last;

    logic                     w_rem_zero;
    logic                     w_rem_one;
    logic                     w_load;
    logic                     w_shift;
    logic [REM_WIDTH-1:0]     w_load_cnt;
    logic [DATA_UP_WIDTH-1:0] w_hold_shifted;

    assign w_rem_zero = (r_rem == '0);
    assign w_rem_one  = (r_rem == REM_WIDTH'(1));

    // Ready when empty, or when the last pending sub-word leaves this cycle.
    assign up_rdy  = ~rst & (w_rem_zero | (w_rem_one & dn_rdy));

    assign dn_val  = ~w_rem_zero;
    assign dn_data = r_hold[DATA_DN_WIDTH-1:0];
    assign dn_last = r_hold_last & w_rem_one;

    // A load takes priority over a shift in the same cycle.
    assign w_load  = up_val & up_rdy;
    assign w_shift = dn_val & dn_rdy & ~w_load;

    // A count of zero encodes a full word.
    assign w_load_cnt = (up_cnt == '0) ? REM_WIDTH'(DATA_NB) : {1'b0, up_cnt};

    // Move every sub-word one slot towards the LSB; the top slot fills with zero.
    generate
        for (genvar gi = 0; gi < DATA_NB; gi++) begin : g_shift
            if (gi < DATA_NB - 1) begin : g_mid
                assign w_hold_shifted[gi*DATA_DN_WIDTH +: DATA_DN_WIDTH] =
                    r_hold[(gi+1)*DATA_DN_WIDTH +: DATA_DN_WIDTH];
            end else begin : g_top
                assign w_hold_shifted[gi*DATA_DN_WIDTH +: DATA_DN_WIDTH] = '0;
            end
        end
    endgenerate

    // Holding register: reset empties it, load refills it, shift drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_rem       <= '0;
            r_hold_last <= 1'b0;
        end else if (w_load) begin
            r_hold      <= up_data;
            r_rem       <= w_load_cnt;
            r_hold_last <= up_last;
        end else if (w_shift) begin
            r_hold      <= w_hold_shifted;
            r_rem       <= r_rem - REM_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_str_unpack.sv
// Self-checking bench for str_unpack: directed steps plus a random regression,
// with a queue scoreboard holding the expected narrow-word stream.
module tb_str_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] up_data = '0;
    logic [1:0]  up_cnt = '0;
    logic        up_last = 1'b0;
    logic        up_val = 1'b0;
    logic        up_rdy;
    logic [7:0]  dn_data;
    logic        dn_last;
    logic        dn_val;
    logic        dn_rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_up_last = 0;
    int n_dn_last = 0;
    int rdy_mode = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       eow;
    } exp_t;
    exp_t q[$];

    str_unpack #(
        .DATA_UP_WIDTH(32),
        .DATA_DN_WIDTH(8),
        .CNT_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_data(up_data),
        .up_cnt(up_cnt),
        .up_last(up_last),
        .up_val(up_val),
        .up_rdy(up_rdy),
        .dn_data(dn_data),
        .dn_last(dn_last),
        .dn_val(dn_val),
        .dn_rdy(dn_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready generator: always ready, a 1,0,0 pattern, or random.
    initial begin
        int ph = 0;
        dn_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    dn_rdy = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: dn_rdy = 1'($urandom_range(0, 1));
                default: dn_rdy = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: compare against the queue head every cycle, pop on
    // a downstream transfer, push counted sub-words on an upstream acceptance.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_rdy;
            exp_rdy = !rst && ((q.size() == 0) || (q[0].eow && dn_rdy));
            check("up_rdy", 32'(up_rdy), 32'(exp_rdy));
            check("dn_val", 32'(dn_val), 32'(q.size() != 0));
            if (q.size() != 0 && dn_val) begin
                check("dn_data", 32'(dn_data), 32'(q[0].data));
                check("dn_last", 32'(dn_last), 32'(q[0].last));
            end
            if (rst) begin
                q.delete();
            end else begin
                if (dn_val && dn_rdy && q.size() != 0) begin
                    if (dn_last) n_dn_last++;
                    void'(q.pop_front());
                end
                if (up_val && up_rdy) begin
                    int k;
                    k = (up_cnt == 2'd0) ? 4 : int'(up_cnt);
                    if (up_last) n_up_last++;
                    for (int i = 0; i < k; i++) begin
                        exp_t e;
                        e.data = up_data[i*8 +: 8];
                        e.last = up_last && (i == k - 1);
                        e.eow  = (i == k - 1);
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Present one wide word and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic [1:0] c, input logic l);
        int waited = 0;
        up_data = d;
        up_cnt  = c;
        up_last = l;
        up_val  = 1'b1;
        @(negedge clk);
        while (!up_rdy && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!up_rdy) check("send_timeout", 32'(up_rdy), 32'(1));
        @(posedge clk);
        #1;
        up_val = 1'b0;
    endtask

    // Wait until every expected sub-word has been emitted (bounded wait).
    task automatic drain();
        int waited = 0;
        @(negedge clk);
        while ((q.size() != 0 || dn_val) && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        check("drain_empty", 32'(q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_up;
        int base_dn;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dn_val", 32'(dn_val), 32'(0));
        check("rst_dn_last", 32'(dn_last), 32'(0));
        check("rst_dn_data", 32'(dn_data), 32'(0));
        check("rst_up_rdy", 32'(up_rdy), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Two full words back to back, always ready.
        rdy_mode = 0;
        send(32'h44332211, 2'd0, 1'b0);
        send(32'h88776655, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_dn_val_busy", 32'(dn_val), 32'(1));
        end
        @(negedge clk);
        check("b2b_dn_val_idle", 32'(dn_val), 32'(0));
        check("b2b_last_count", 32'(n_dn_last), 32'(1));
        @(posedge clk);
        #1;

        // Partial tail: only AA and BB, last on BB.
        send(32'hDDCCBBAA, 2'd2, 1'b1);
        @(negedge clk);
        check("tail_aa", 32'(dn_data), 32'(8'hAA));
        @(negedge clk);
        check("tail_bb", 32'(dn_data), 32'(8'hBB));
        check("tail_bb_last", 32'(dn_last), 32'(1));
        @(negedge clk);
        check("tail_idle", 32'(dn_val), 32'(0));
        @(posedge clk);
        #1;

        // Back-pressure with a 1,0,0 ready pattern, then a follow-up word.
        rdy_mode = 1;
        send(32'hC3C2C1C0, 2'd0, 1'b0);
        send(32'hD2D1D0CF, 2'd3, 1'b1);
        drain();
        rdy_mode = 0;

        // Non-last partial word followed directly by another word.
        send(32'h0000E1E0, 2'd2, 1'b0);
        send(32'hF3F2F1F0, 2'd1, 1'b1);
        drain();

        // Reset after two of four sub-words have been emitted.
        send(32'hA4A3A2A1, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_up_rdy", 32'(up_rdy), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dn_val", 32'(dn_val), 32'(0));
        @(posedge clk);
        #1;
        send(32'hB4B3B2B1, 2'd0, 1'b1);
        @(negedge clk);
        check("postrst_first", 32'(dn_data), 32'(8'hB1));
        drain();

        // Random regression.
        base_up = n_up_last;
        base_dn = n_dn_last;
        rdy_mode = 2;
        for (int w = 0; w < 200; w++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        drain();
        check("rand_last_count", 32'(n_dn_last - base_dn), 32'(n_up_last - base_up));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/str_unpack.md
Name: str_unpack

Overview:
- Stream unpacker: takes wide words, each tagged with a count of valid sub-words, and emits them as a sequence of narrow words.
- Emits only the counted sub-words, LSB sub-word first, and skips unused upper sub-words.
- It is the receiving-side counterpart of the deserializing gearbox: it recovers variable-length tails that were packed into partial wide words by an up_last-forced transfer.
- Sits between wide datapath buffers (e.g. memory read ports) and narrow stream consumers, using the codebase's val/rdy/last stream handshake.

Parameters:
- DATA_UP_WIDTH, 32, width of the incoming wide word; must be an integer multiple (>=2) of DATA_DN_WIDTH.
- DATA_DN_WIDTH, 8, width of each outgoing narrow word.
- CNT_WIDTH, 2, width of up_cnt; must equal clog2(DATA_UP_WIDTH/DATA_DN_WIDTH).
- Derived localparam: DATA_NB = DATA_UP_WIDTH/DATA_DN_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- up_data  in  DATA_UP_WIDTH  wide word; sub-word 0 at bits [DATA_DN_WIDTH-1:0].
- up_cnt  in  CNT_WIDTH  number of valid sub-words; 0 encodes DATA_NB (full word).
- up_last  in  1  word is the final word of its packet.
- up_val  in  1  upstream valid.
- up_rdy  out  1  upstream ready.
- dn_data  out  DATA_DN_WIDTH  narrow word.
- dn_last  out  1  final narrow word of packet.
- dn_val  out  1  downstream valid.
- dn_rdy  in  1  downstream ready.

Behaviour:
- Reset values: dn_val=0, dn_last=0, dn_data=0. up_rdy=0 while rst is high; the holding register is marked empty.
- State registers:
  - hold: DATA_UP_WIDTH shift register.
  - rem: remaining sub-words, range 0..DATA_NB.
  - hold_last: 1 bit.
- dn_val = (rem!=0). dn_data = hold[DATA_DN_WIDTH-1:0]. dn_last = hold_last & (rem==1).
- up_rdy = ~rst & ((rem==0) | (rem==1 & dn_rdy)). This is combinational from dn_rdy and allows back-to-back words with no bubble.
- Load happens when up_val & up_rdy:
  - hold <= up_data.
  - rem <= (up_cnt==0 ? DATA_NB : up_cnt).
  - hold_last <= up_last.
  - Latency: dn_val rises the cycle after acceptance.
- Shift happens when dn_val & dn_rdy and no load occurs in the same cycle:
  - hold <= hold >> DATA_DN_WIDTH.
  - rem <= rem-1.
- Simultaneous final-subword consume and new load: the load wins and no empty cycle is inserted.
- Stall: while dn_val & ~dn_rdy, dn_data, dn_last and dn_val are held stable.
  - dn_val never falls without a transfer.
  - up_rdy stays low unless rem==0.
- Throughput:
  - A full word occupies DATA_NB consecutive dn cycles.
  - A word with count k occupies k cycles.
  - Sustained up acceptance is 1 word per k cycles.
- Counts and last:
  - up_cnt>DATA_NB is impossible by encoding.
  - Sub-words above the count are never emitted.
  - up_last on a word with count k asserts dn_last only on its k-th narrow word.
  - A non-last word with count k<DATA_NB is legal: its k sub-words are emitted, then the next word follows with no dn_last between them.
- Reset mid-operation: rst clears rem. Any partially emitted word is discarded and dn_val drops the next cycle; no residue is emitted after reset.
- up_data, up_cnt and up_last are sampled only on acceptance.
- Upstream is required to hold them stable while up_val & ~up_rdy.

Test Plan:
- Full words, default params, dn_rdy=1: up words 0x44332211 (cnt=0) then 0x88776655 (cnt=0, last) -> dn sees 11,22,33,44,55,66,77,88 on 8 consecutive cycles, dn_last only with 88, up_rdy high on the 4th beat of each word.
- Partial tail: 0xDDCCBBAA with cnt=2, last=1 -> dn emits AA then BB (dn_last=1 on BB); CC and DD are never emitted; dn_val=0 the following cycle if no new word arrives.
- Back-pressure: dn_rdy toggles 1,0,0,1,... during a full word -> every byte is emitted exactly once in order, dn_data is stable during stalls, and up_rdy=0 until the final beat is consumed.
- Back-to-back load: a new word with up_val held high -> it is accepted in the same cycle the previous word's final sub-word is consumed, with zero idle dn cycles between words.
- Reset mid-word: assert rst after 2 of 4 bytes are emitted -> dn_val=0 the next cycle and up_rdy=0 during rst; a fresh word after reset emits from its sub-word 0 with no stale bytes.
- Random regression: random up_cnt, up_last, up_val and dn_rdy -> a scoreboard check that the output byte stream equals the concatenated counted sub-words, and that dn_last count equals the number of up_last words.
